// File: rtl/booth_radix4_multiplication.sv
// ============================================================================
// Module   : booth_radix4_multiplication
// Function : Sequential unsigned multiplier, one radix-4 Booth digit per clock.
//            Optional overflow flag is enabled by BOOTH_RADIX4_MULT_OV_FLAG_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_radix4_multiplication #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      enable_in,
   input  logic [DATA_WIDTH-1:0]     multiplicand,
   input  logic [DATA_WIDTH-1:0]     multiplier,
   output logic                      busy,
   output logic                      done,
   output logic                      ov_flag,
   output logic [2*DATA_WIDTH-1:0]   product
);

   localparam int N_DIGITS = DATA_WIDTH / 2 + 1;
   localparam int CNT_W    = $clog2(N_DIGITS);
   localparam int ACC_W    = DATA_WIDTH + 3;
   localparam int BR_W     = DATA_WIDTH + 3;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_DIGITS - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_RUN  = 3'b010,
      S_DONE = 3'b100
   } state_t;

   state_t                      state;
   state_t                      next_state;
   logic [DATA_WIDTH-1:0]       a_reg;
   logic signed [ACC_W-1:0]     acc;
   logic [BR_W-1:0]             b_reg;
   logic [CNT_W-1:0]            cnt;
   logic signed [ACC_W-1:0]     pp;
   logic signed [ACC_W-1:0]     sum;
   logic signed [ACC_W+BR_W-1:0] shifted;
   logic [2*DATA_WIDTH-1:0]     result;

   // b_reg[2:0] is the current triplet; bit 0 holds the previous digit's top bit
   always_comb begin
      pp = '0;
      case (b_reg[2:0])
         3'b001, 3'b010: pp = {3'b000, a_reg};
         3'b011:         pp = {2'b00, a_reg, 1'b0};
         3'b100:         pp = -$signed({2'b00, a_reg, 1'b0});
         3'b101, 3'b110: pp = -$signed({3'b000, a_reg});
         default:        pp = '0;
      endcase
   end

   assign sum     = acc + pp;
   assign shifted = $signed({sum, b_reg}) >>> 2;
   assign result  = {acc[DATA_WIDTH-3:0], b_reg[BR_W-1:1]};
   assign busy    = (state == S_RUN) || (state == S_DONE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = S_IDLE;
      case (state)
         S_IDLE:  next_state = enable_in ? S_RUN : S_IDLE;
         S_RUN:   next_state = (cnt != '0) ? S_RUN : S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_reg   <= '0;
         acc     <= '0;
         b_reg   <= '0;
         cnt     <= '0;
         product <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable_in) begin
                  a_reg <= multiplicand;
                  b_reg <= {2'b00, multiplier, 1'b0};
                  acc   <= '0;
                  cnt   <= CNT_LOAD;
               end
            end
            S_RUN: begin
               acc   <= shifted[ACC_W+BR_W-1:BR_W];
               b_reg <= shifted[BR_W-1:0];
               cnt   <= cnt - CNT_W'(1);
            end
            S_DONE: begin
               product <= result;
               done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef BOOTH_RADIX4_MULT_OV_FLAG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)              ov_flag <= 1'b0;
      else if (state == S_DONE)  ov_flag <= |result[2*DATA_WIDTH-1:DATA_WIDTH];
   end
`else
   assign ov_flag = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/booth_radix4_multiplication.md
# booth_radix4_multiplication

Sequential unsigned multiplier using radix-4 modified Booth recoding: one Booth digit per clock, full 2×DATA_WIDTH-bit product. It is the multiply counterpart to the team's SRT radix-4 divider and uses the same start/run/done control style. Datapaths use it to rebuild dividend = quotient × divisor + remainder, and as a general multi-cycle multiplier where a DSP block is too costly.

## Interface
- DATA_WIDTH, 8, operand width; must be even and ≥ 4
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- enable_in  input  1  start request; sampled only in S_IDLE
- multiplicand  input  DATA_WIDTH  unsigned operand A; captured when start is accepted
- multiplier  input  DATA_WIDTH  unsigned operand B, Booth-recoded; captured when start is accepted
- busy  output  1  high in S_RUN and S_DONE
- done  output  1  one-cycle pulse when product is updated
- ov_flag  output  1  product does not fit in DATA_WIDTH bits (see Configuration)
- product  output  2*DATA_WIDTH  unsigned A×B; holds its value until the next completion

## Operation
- FSM states: S_IDLE, S_RUN, S_DONE. Encoding is one-hot.
  - S_IDLE → S_RUN when enable_in = 1; otherwise stays in S_IDLE.
  - S_RUN → S_RUN while digit counter ≠ 0; otherwise → S_DONE.
  - S_DONE → S_IDLE unconditionally.
  - Any illegal state → S_IDLE.
- Start accept (S_IDLE, enable_in = 1):
  - Register A.
  - Register B zero-extended to DATA_WIDTH+2 bits, with an implicit 0 appended on the right.
  - Clear the accumulator.
  - Load digit counter with N−1, where N = DATA_WIDTH/2 + 1.
- S_RUN, each cycle:
  - Recode triplet {b[2i+1], b[2i], b[2i−1]} to a digit d ∈ {−2, −1, 0, +1, +2}: 000/111 → 0, 001/010 → +1, 011 → +2, 100 → −2, 101/110 → −1.
  - Add d×A, sign-extended to DATA_WIDTH+3 bits, to the accumulator high part.
  - Arithmetic shift right 2 across the accumulator and multiplier register.
  - Decrement the digit counter.
- Arithmetic: high part is signed, DATA_WIDTH+3 bits; −2A uses two's-complement of A shifted left by 1. The final value is exact and non-negative. product = the low 2*DATA_WIDTH bits of the combined register.
- S_DONE: register product and ov_flag; assert done.
- enable_in outside S_IDLE is ignored. No queuing; operands on those cycles are discarded.
- Operand 0 on either side gives product 0 and needs no special path. Cycle count is the same for all operands.

## Timing
- Reset values: busy = 0, done = 0, ov_flag = 0, product = 0; FSM in S_IDLE; all internal registers 0.
- Start sampled at edge E0.
- Edges E1..EN run in S_RUN.
- Edge EN+1 (in S_DONE) updates product and ov_flag and sets done = 1.
- done is high for exactly one cycle, between edges EN+1 and EN+2.
- Latency is N+1 cycles from the sampling edge: 6 for DATA_WIDTH = 8, 10 for DATA_WIDTH = 16.
- The FSM is back in S_IDLE after EN+1. If enable_in is high during the done cycle, a new start is accepted at EN+2. Maximum issue rate is one per N+2 cycles.
- busy rises after E0 and falls after EN+1.
- reset_n low at any time, including mid-run: immediate return to reset values. The operation in flight is lost and done is not pulsed.

## Configuration
- Macro: BOOTH_RADIX4_MULT_OV_FLAG_EN.
- Defined: at S_DONE, ov_flag <= |product[2*DATA_WIDTH−1 : DATA_WIDTH]; it holds until the next completion.
- Undefined: ov_flag is tied to 0 and the OR-reduce logic is not built.
- All other behaviour is identical in both builds.

## Test plan
- W=8, A=13, B=11, enable_in high for 1 cycle → done exactly 6 cycles after the sampling edge; product = 0x008F; ov_flag = 0.
- W=8, A=255, B=255 → product = 0xFE01; ov_flag = 1 with the macro, 0 without. Then A=0, B=200 → product = 0x0000, ov_flag = 0.
- W=8, start A=3, B=5; pulse enable_in with A=7, B=7 on cycles 2–4 → product = 0x000F; a single done pulse; busy stays high.
- W=8, start A=100, B=100; reset_n low for 1 cycle at cycle 3 → all outputs 0, no done; then start A=2, B=3 → product = 0x0006 after 6 cycles.
- enable_in held high continuously with A=B=16 → done every 7 cycles; product = 0x0100 each time.
- W=16, 10000 random operand pairs → product = A×B (0x0000_0000..0xFFFE_0001); latency 10 every time.
